// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI timing generator. It issues pixel requests ahead of display time
// and emits colour, sync and DE together after a matched delay.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int H_POL       = 0,
  parameter int V_POL       = 0,
  parameter int DEEP_COLOR  = 4,
  parameter int PIX_LATENCY = 2,
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int COL_W      = $clog2(H_TOTAL),
  localparam int LINE_W     = $clog2(V_TOTAL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [23:0]           pixel,
  output logic [COL_W-1:0]      col_req,
  output logic [LINE_W-1:0]     line_req,
  output logic                  req_valid,
  output logic                  line_start,
  output logic                  frame_start,
  output logic [DEEP_COLOR-1:0] R,
  output logic [DEEP_COLOR-1:0] G,
  output logic [DEEP_COLOR-1:0] B,
  output logic                  HS,
  output logic                  VS,
  output logic                  DE
);

  if (DEEP_COLOR < 1 || DEEP_COLOR > 8) begin : g_bad_deep_color
    $error("vga_timing_gen: DEEP_COLOR must be in 1..8");
  end
  if (PIX_LATENCY < 0 || PIX_LATENCY > 15) begin : g_bad_latency
    $error("vga_timing_gen: PIX_LATENCY must be in 0..15");
  end
  if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1) begin : g_bad_zero_len
    $error("vga_timing_gen: active and sync lengths must be non-zero");
  end
  if (H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_porch
    $error("vga_timing_gen: porch lengths must not be negative");
  end

  // Inclusive bounds keep every constant below H_TOTAL/V_TOTAL, so they fit the counter width
  // even when the back porch is zero.
  localparam logic [COL_W-1:0]  H_LAST      = COL_W'(H_TOTAL - 1);
  localparam logic [COL_W-1:0]  H_ACT_LAST  = COL_W'(H_ACTIVE - 1);
  localparam logic [COL_W-1:0]  HS_FIRST    = COL_W'(H_ACTIVE + H_FP);
  localparam logic [COL_W-1:0]  HS_LAST     = COL_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [LINE_W-1:0] V_LAST      = LINE_W'(V_TOTAL - 1);
  localparam logic [LINE_W-1:0] V_ACT_LAST  = LINE_W'(V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] VS_FIRST    = LINE_W'(V_ACTIVE + V_FP);
  localparam logic [LINE_W-1:0] VS_LAST     = LINE_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic              HS_ON       = H_POL[0];
  localparam logic              VS_ON       = V_POL[0];

  logic [COL_W-1:0]  h_cnt;
  logic [LINE_W-1:0] v_cnt;
  logic              hs_raw;
  logic              vs_raw;
  logic [2:0]        req_flags;
  logic [2:0]        dly_flags;
  logic              dly_valid;
  logic              dly_hs;
  logic              dly_vs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + LINE_W'(1);
        end
      end else begin
        h_cnt <= h_cnt + COL_W'(1);
      end
    end
  end

  // Request contract: the source sees (col_req, line_req) on an en cycle and must present the
  // matching pixel on the pixel input exactly PIX_LATENCY en-cycles later; there is no back-pressure.
  assign col_req     = h_cnt;
  assign line_req    = v_cnt;
  assign req_valid   = (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);
  assign line_start  = en && (h_cnt == '0);
  assign frame_start = en && (h_cnt == '0) && (v_cnt == '0);
  assign hs_raw      = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_raw      = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

  assign req_flags = {req_valid, hs_raw, vs_raw};

  // Flags stay in raw (active-high) form through the delay line; polarity is applied at the pins.
  if (PIX_LATENCY == 0) begin : g_no_delay
    assign dly_flags = req_flags;
  end else begin : g_delay
    logic [PIX_LATENCY-1:0][2:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage <= '0;
      end else if (en) begin
        stage[0] <= req_flags;
        for (int i = 1; i < PIX_LATENCY; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign dly_flags = stage[PIX_LATENCY-1];
  end

  assign dly_valid = dly_flags[2];
  assign dly_hs    = dly_flags[1];
  assign dly_vs    = dly_flags[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R  <= '0;
      G  <= '0;
      B  <= '0;
      DE <= 1'b0;
      HS <= ~HS_ON;
      VS <= ~VS_ON;
    end else if (en) begin
      DE <= dly_valid;
      HS <= dly_hs ? HS_ON : ~HS_ON;
      VS <= dly_vs ? VS_ON : ~VS_ON;
      if (dly_valid) begin
        R <= pixel[23 -: DEEP_COLOR];
        G <= pixel[15 -: DEEP_COLOR];
        B <= pixel[7  -: DEEP_COLOR];
      end else begin
        R <= '0;
        G <= '0;
        B <= '0;
      end
    end
  end

  // Low-order colour bits are deliberately dropped when DEEP_COLOR < 8.
  logic unused_pixel_bits;
  assign unused_pixel_bits = ^pixel;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small 8x6 raster: directed vector table,
// random enable/pixel stimulus against a frame-position model, and a mid-frame reset.
module tb_vga_timing_gen;

  localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
  localparam int LAT = 2, DC = 4;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int W  = 3 + 3 * DC;
  localparam logic HPOL = 1'b0, VPOL = 1'b0;
  localparam logic [W-1:0] BLANK = {1'b0, ~HPOL, ~VPOL, {(3*DC){1'b0}}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [23:0]   pixel = '0;
  logic [2:0]    col_req;
  logic [2:0]    line_req;
  logic          req_valid, line_start, frame_start;
  logic [DC-1:0] R, G, B;
  logic          HS, VS, DE;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .H_POL(0), .V_POL(0), .DEEP_COLOR(DC), .PIX_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel(pixel),
    .col_req(col_req), .line_req(line_req), .req_valid(req_valid),
    .line_start(line_start), .frame_start(frame_start),
    .R(R), .G(G), .B(B), .HS(HS), .VS(VS), .DE(DE)
  );

  // clock block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;
  int m;                            // en-edges since reset release = request index
  logic [W-1:0]  exp_q[$];          // expected pin word per en-cycle, front = currently visible
  logic [23:0]   pix_q[$];          // pixels still to be presented, front = due this cycle
  logic [23:0]   forced_pix[int];

  typedef struct {
    int            k;
    logic [23:0]   pix;
    logic          de, hs, vs;
    logic [DC-1:0] r, g, b;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (request index %0d)", name, act, want, m);
    end
  endtask

  // Expected pins for request k, derived from its raster position.
  function automatic logic [W-1:0] expect_for(input int k, input logic [23:0] px);
    int col, line;
    logic vis, hs_on, vs_on;
    logic [DC-1:0] r, g, b;
    col   = k % HT;
    line  = (k / HT) % VT;
    vis   = (col < HA) && (line < VA);
    hs_on = (col >= HA + HF) && (col < HA + HF + HSW);
    vs_on = (line >= VA + VF) && (line < VA + VF + VSW);
    r = vis ? DC'(px[23:16] >> (8 - DC)) : '0;
    g = vis ? DC'(px[15:8]  >> (8 - DC)) : '0;
    b = vis ? DC'(px[7:0]   >> (8 - DC)) : '0;
    return {vis, hs_on ? HPOL : ~HPOL, vs_on ? VPOL : ~VPOL, r, g, b};
  endfunction

  task automatic reset_model();
    m = 0;
    exp_q.delete();
    pix_q.delete();
    for (int i = 0; i < LAT + 1; i++) exp_q.push_back(BLANK);
    for (int i = 0; i < LAT; i++) pix_q.push_back(24'($urandom));
  endtask

  task automatic advance();
    logic [23:0] px;
    px = forced_pix.exists(m) ? forced_pix[m] : 24'($urandom);
    pix_q.push_back(px);
    void'(pix_q.pop_front());
    exp_q.push_back(expect_for(m, px));
    void'(exp_q.pop_front());
    m++;
  endtask

  task automatic check_cycle();
    int col, line;
    col  = m % HT;
    line = (m / HT) % VT;
    chk("col_req",     32'(col_req),     32'(col));
    chk("line_req",    32'(line_req),    32'(line));
    chk("req_valid",   32'(req_valid),   32'((col < HA) && (line < VA)));
    chk("line_start",  32'(line_start),  32'(en && (col == 0)));
    chk("frame_start", 32'(frame_start), 32'(en && (m % FT == 0)));
    chk("pins",        32'({DE, HS, VS, R, G, B}), 32'(exp_q[0]));
  endtask

  // driver task: entered and left at posedge+1
  task automatic step(input logic en_v);
    en    = en_v;
    pixel = en_v ? pix_q[0] : 24'($urandom);
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    if (en_v) advance();
    #1;
  endtask

  initial begin
    int guard;
    tbl[0]  = '{1,  24'hA5C3F0, 1'b1, 1'b1, 1'b1, 4'hA, 4'hC, 4'hF};
    tbl[1]  = '{3,  24'h12345F, 1'b1, 1'b1, 1'b1, 4'h1, 4'h3, 4'h5};
    tbl[2]  = '{4,  24'hFFFFFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{5,  24'h808080, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{6,  24'hFFFFFF, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{7,  24'hFFFFFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    tbl[6]  = '{8,  24'h0F0F0F, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{18, 24'hF7E8D9, 1'b1, 1'b1, 1'b1, 4'hF, 4'hE, 4'hD};
    tbl[8]  = '{24, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    tbl[9]  = '{32, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[10] = '{37, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{40, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    tbl[12] = '{49, 24'h9ABCDE, 1'b1, 1'b1, 1'b1, 4'h9, 4'hB, 4'hD};
    foreach (tbl[i]) forced_pix[tbl[i].k] = tbl[i].pix;

    // reset block
    rst_n = 1'b0;
    en    = 1'b1;
    pixel = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    m = 0;
    chk("rst_col_req",     32'(col_req),     32'd0);
    chk("rst_line_req",    32'(line_req),    32'd0);
    chk("rst_req_valid",   32'(req_valid),   32'd1);
    chk("rst_line_start",  32'(line_start),  32'd1);
    chk("rst_frame_start", 32'(frame_start), 32'd1);
    chk("rst_pins",        32'({DE, HS, VS, R, G, B}), 32'(BLANK));

    rst_n = 1'b1;
    reset_model();

    // directed vectors, en held high
    foreach (tbl[i]) begin
      guard = 0;
      while (m < tbl[i].k + LAT + 1 && guard < 200) begin
        step(1'b1);
        guard++;
      end
      if (m != tbl[i].k + LAT + 1) begin
        chk("vec_reach", 32'(m), 32'(tbl[i].k + LAT + 1));
      end else begin
        chk($sformatf("vec%0d_pins", i), 32'({DE, HS, VS, R, G, B}),
            32'({tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].r, tbl[i].g, tbl[i].b}));
      end
    end

    repeat (60) step(1'b1);
    for (int i = 0; i < 200; i++) step(i % 2 == 0);
    repeat (400) step(1'($urandom_range(0, 1)));

    // mid-frame reset at (5,2)
    guard = 0;
    while (m % FT != 2 * HT + 5 && guard < 200) begin
      step(1'b1);
      guard++;
    end
    chk("mid_reach", 32'(m % FT), 32'(2 * HT + 5));
    en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pins",        32'({DE, HS, VS, R, G, B}), 32'(BLANK));
    chk("mid_rst_col_req",     32'(col_req),     32'd0);
    chk("mid_rst_line_req",    32'(line_req),    32'd0);
    chk("mid_rst_frame_start", 32'(frame_start), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    repeat (120) step(1'b1);
    repeat (100) step(1'($urandom_range(0, 1)));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
